// File: rtl/mem_stride_master_if.sv
// rtl/mem_stride_master_if.sv - DataMemory request/done port shared by the initiator and the memory
interface mem_stride_master_if #(
  parameter int AW = 20
);
  logic [AW-1:0] address;
  logic [63:0]   data_in;
  logic [7:0]    bytemask;
  logic          write;
  logic          start_access;
  logic          access_done;
  logic [63:0]   data_out;

  modport master (
    output address, data_in, bytemask, write, start_access,
    input  access_done, data_out
  );

  modport slave (
    input  address, data_in, bytemask, write, start_access,
    output access_done, data_out
  );
endinterface

// File: rtl/mem_stride_master.sv
// rtl/mem_stride_master.sv - strided burst initiator for DataMemory with read streaming and latency stats
module mem_stride_master #(
  parameter int DMEM_ADDRESS_WIDTH = 20,
  parameter int COUNT_WIDTH        = 16,
  parameter int LAT_WIDTH          = 16,
  parameter int TIMEOUT            = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [DMEM_ADDRESS_WIDTH-1:0] cmd_base,
  input  logic [DMEM_ADDRESS_WIDTH-1:0] cmd_stride,
  input  logic [COUNT_WIDTH-1:0]        cmd_count,
  input  logic                          cmd_write,
  input  logic [63:0]                   cmd_wdata,
  input  logic [7:0]                    cmd_bytemask,
  mem_stride_master_if.master           mem,
  output logic                          rd_valid,
  output logic [63:0]                   rd_data,
  output logic [COUNT_WIDTH-1:0]        rd_index,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [LAT_WIDTH-1:0]          min_lat,
  output logic [LAT_WIDTH-1:0]          max_lat,
  output logic [LAT_WIDTH-1:0]          total_cycles
);

  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;

  localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;
  localparam logic [LAT_WIDTH-1:0] LAT_TO  = LAT_WIDTH'(TIMEOUT);

  state_t                        state;
  logic [DMEM_ADDRESS_WIDTH-1:0] addr_r;
  logic [DMEM_ADDRESS_WIDTH-1:0] stride_r;
  logic [63:0]                   data_r;
  logic [7:0]                    mask_r;
  logic                          write_r;
  logic                          start_r;
  logic [COUNT_WIDTH-1:0]        idx;
  logic [COUNT_WIDTH-1:0]        count_r;
  logic [LAT_WIDTH-1:0]          lat;

  logic [LAT_WIDTH-1:0]   lat_now;
  logic [LAT_WIDTH-1:0]   total_inc;
  logic [COUNT_WIDTH:0]   idx_inc;
  logic                   more;
  logic                   misaligned;

  assign mem.address      = addr_r;
  assign mem.data_in      = data_r;
  assign mem.bytemask     = mask_r;
  assign mem.write        = write_r;
  assign mem.start_access = start_r;

  // lat_now includes the current cycle, so the access_done cycle counts and the minimum is 1
  assign lat_now    = (lat == LAT_MAX) ? lat : lat + LAT_WIDTH'(1);
  assign total_inc  = (total_cycles == LAT_MAX) ? total_cycles : total_cycles + LAT_WIDTH'(1);
  assign idx_inc    = {1'b0, idx} + {{COUNT_WIDTH{1'b0}}, 1'b1};
  assign more       = idx_inc < {1'b0, count_r};
  assign misaligned = (cmd_base[2:0] != 3'b000) || (cmd_stride[2:0] != 3'b000);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr_r       <= '0;
      stride_r     <= '0;
      data_r       <= '0;
      mask_r       <= '0;
      write_r      <= 1'b0;
      start_r      <= 1'b0;
      idx          <= '0;
      count_r      <= '0;
      lat          <= '0;
      cmd_ready    <= 1'b1;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_index     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      min_lat      <= LAT_MAX;
      max_lat      <= '0;
      total_cycles <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            error        <= 1'b0;
            total_cycles <= '0;
            max_lat      <= '0;
            min_lat      <= LAT_MAX;
            count_r      <= cmd_count;
            stride_r     <= cmd_stride;
            idx          <= '0;
            lat          <= '0;
            addr_r       <= cmd_base;
            write_r      <= cmd_write;
            data_r       <= cmd_write ? cmd_wdata : 64'd0;
            mask_r       <= cmd_write ? cmd_bytemask : 8'd0;
            if (misaligned) begin
              error   <= 1'b1;
              min_lat <= '0;
              done    <= 1'b1;
              state   <= FINISH;
            end else if (cmd_count == '0) begin
              min_lat <= '0;
              done    <= 1'b1;
              state   <= FINISH;
            end else begin
              start_r <= 1'b1;
              state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          total_cycles <= total_inc;
          // Timeout only flags; the request must stay up until the memory answers
          if (lat_now == LAT_TO) error <= 1'b1;
          if (mem.access_done) begin
            lat <= '0;
            if (lat_now < min_lat) min_lat <= lat_now;
            if (lat_now > max_lat) max_lat <= lat_now;
            if (!write_r) begin
              rd_data  <= mem.data_out;
              rd_index <= idx;
              rd_valid <= 1'b1;
            end
            if (more) begin
              addr_r <= addr_r + stride_r;
              idx    <= idx_inc[COUNT_WIDTH-1:0];
              if (write_r) data_r <= data_r + 64'd1;
            end else begin
              start_r <= 1'b0;
              done    <= 1'b1;
              state   <= FINISH;
            end
          end else begin
            lat <= lat_now;
          end
        end
        FINISH: begin
          total_cycles <= total_inc;
          busy         <= 1'b0;
          cmd_ready    <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stride_master.sv
// tb/tb_mem_stride_master.sv - directed bench for mem_stride_master with a behavioural DataMemory
module tb_mem_stride_master;
  localparam int AW = 20;
  localparam int CW = 16;
  localparam int LW = 16;
  localparam int TO = 4096;

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW-1:0] cmd_stride;
  logic [CW-1:0] cmd_count;
  logic          cmd_write;
  logic [63:0]   cmd_wdata;
  logic [7:0]    cmd_bytemask;
  logic          rd_valid;
  logic [63:0]   rd_data;
  logic [CW-1:0] rd_index;
  logic          busy;
  logic          done;
  logic          error;
  logic [LW-1:0] min_lat;
  logic [LW-1:0] max_lat;
  logic [LW-1:0] total_cycles;

  mem_stride_master_if #(.AW(AW)) mif ();

  mem_stride_master #(
    .DMEM_ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW), .LAT_WIDTH(LW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_count(cmd_count),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_bytemask(cmd_bytemask),
    .mem(mif), .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index),
    .busy(busy), .done(done), .error(error), .min_lat(min_lat), .max_lat(max_lat),
    .total_cycles(total_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] mem_arr [int unsigned];
  int          lat_tab [4];
  int          acc_n;
  int          wcnt;
  logic [AW-1:0] addr_q [$];
  logic [63:0] rdd_q [$];
  logic [CW-1:0] rdi_q [$];
  int          done_cnt, rises, sa_cycles, rdnz;
  logic        prev_sa;

  function automatic logic [63:0] rd_word(input logic [AW-1:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  // Memory responds on the falling edge; access_done lasts exactly one cycle
  always @(negedge clk) begin
    if (!reset_n) begin
      mif.access_done = 1'b0;
      wcnt = 0;
    end else begin
      if (mif.access_done) begin
        mif.access_done = 1'b0;
        wcnt = 0;
      end
      if (mif.start_access) begin
        wcnt++;
        if (wcnt >= lat_tab[acc_n % 4]) begin
          logic [63:0] w;
          addr_q.push_back(mif.address);
          if (mif.write) begin
            w = rd_word(mif.address);
            for (int b = 0; b < 8; b++)
              if (mif.bytemask[b]) w[8*b +: 8] = mif.data_in[8*b +: 8];
            mem_arr[int'(mif.address)] = w;
          end else begin
            mif.data_out = rd_word(mif.address);
          end
          acc_n++;
          mif.access_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      rdd_q.push_back(rd_data);
      rdi_q.push_back(rd_index);
    end
    if (done) done_cnt++;
    if (mif.start_access && !prev_sa) rises++;
    if (mif.start_access) sa_cycles++;
    if (mif.start_access && !mif.write && (mif.data_in != 0 || mif.bytemask != 0)) rdnz++;
    prev_sa = mif.start_access;
  end

  task automatic clear_mon();
    addr_q.delete();
    rdd_q.delete();
    rdi_q.delete();
    done_cnt = 0; rises = 0; sa_cycles = 0; rdnz = 0; acc_n = 0;
  endtask

  task automatic send_cmd(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input logic [CW-1:0] cnt, input logic wr,
                          input logic [63:0] wdata, input logic [7:0] mask);
    @(negedge clk);
    cmd_base = base; cmd_stride = stride; cmd_count = cnt;
    cmd_write = wr; cmd_wdata = wdata; cmd_bytemask = mask;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_count = '0;
    cmd_write = 1'b0; cmd_wdata = '0; cmd_bytemask = '0;
    mif.access_done = 1'b0; mif.data_out = '0;
    lat_tab = '{1, 1, 1, 1};
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, error, rd_valid, mif.start_access} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=100000", {cmd_ready, busy, done, error, rd_valid, mif.start_access});
    end
    checks++;
    if ({min_lat, max_lat, total_cycles} !== {16'hFFFF, 16'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset_stats got=%h/%h/%h exp=ffff/0000/0000", min_lat, max_lat, total_cycles);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_burst();
    bit ok;
    logic [63:0] exp_d [4] = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    for (int i = 0; i < 4; i++) mem_arr[i * 8] = exp_d[i];
    lat_tab = '{1, 3, 2, 1};
    clear_mon();
    send_cmd(20'h0, 20'h8, 16'd4, 1'b0, 64'h0, 8'h0);
    wait_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rd_done got=timeout exp=done"); end
    checks++;
    if (rdi_q.size() !== 4 || done_cnt !== 1) begin
      failures++;
      $display("FAIL rd_counts got=%0d reads %0d dones exp=4 reads 1 done", rdi_q.size(), done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdi_q[i] !== CW'(i) || rdd_q[i] !== exp_d[i] || addr_q[i] !== AW'(i * 8)) begin
        failures++;
        $display("FAIL rd_beat%0d got=idx %0d data %h addr %h exp=idx %0d data %h addr %h",
                 i, rdi_q[i], rdd_q[i], addr_q[i], i, exp_d[i], i * 8);
      end
    end
    checks++;
    if (rises !== 1 || sa_cycles !== 7) begin
      failures++;
      $display("FAIL rd_back_to_back got=rises %0d cycles %0d exp=rises 1 cycles 7", rises, sa_cycles);
    end
    checks++;
    if ({min_lat, max_lat, total_cycles} !== {16'd1, 16'd3, 16'd8} || error !== 1'b0) begin
      failures++;
      $display("FAIL rd_stats got=%0d/%0d/%0d err %b exp=1/3/8 err 0", min_lat, max_lat, total_cycles, error);
    end
  endtask

  task automatic test_write_readback();
    bit ok;
    lat_tab = '{2, 2, 2, 2};
    clear_mon();
    send_cmd(20'h100, 20'h8, 16'd3, 1'b1, 64'h10, 8'hFF);
    wait_done(100, ok);
    checks++;
    if (!ok || addr_q.size() !== 3 || rdi_q.size() !== 0) begin
      failures++;
      $display("FAIL wr_burst got=ok %0b accesses %0d reads %0d exp=ok 1 accesses 3 reads 0", ok, addr_q.size(), rdi_q.size());
    end
    clear_mon();
    send_cmd(20'h100, 20'h8, 16'd3, 1'b0, 64'h0, 8'h0);
    wait_done(100, ok);
    checks++;
    if (!ok || rdd_q.size() !== 3) begin
      failures++;
      $display("FAIL wr_readback_count got=ok %0b reads %0d exp=ok 1 reads 3", ok, rdd_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdd_q[i] !== 64'h10 + 64'(i)) begin
        failures++;
        $display("FAIL wr_readback%0d got=%h exp=%h", i, rdd_q[i], 64'h10 + 64'(i));
      end
    end
    checks++;
    if (rdnz !== 0) begin
      failures++;
      $display("FAIL rd_wdata_zero got=%0d nonzero cycles exp=0", rdnz);
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    lat_tab = '{1, 1, 1, 1};
    clear_mon();
    send_cmd(20'h4, 20'h8, 16'd2, 1'b0, 64'h0, 8'h0);
    wait_done(2, ok);
    checks++;
    if (!ok || rises !== 0 || error !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_base got=ok %0b rises %0d err %b exp=ok 1 rises 0 err 1", ok, rises, error);
    end
    clear_mon();
    send_cmd(20'h0, 20'hC, 16'd2, 1'b0, 64'h0, 8'h0);
    wait_done(2, ok);
    checks++;
    if (!ok || rises !== 0 || error !== 1'b1 || total_cycles !== 16'd1) begin
      failures++;
      $display("FAIL misaligned_stride got=ok %0b rises %0d err %b total %0d exp=ok 1 rises 0 err 1 total 1",
               ok, rises, error, total_cycles);
    end
  endtask

  task automatic test_count_zero_and_wrap();
    bit ok;
    clear_mon();
    send_cmd(20'h0, 20'h8, 16'd0, 1'b0, 64'h0, 8'h0);
    wait_done(3, ok);
    checks++;
    if (!ok || rises !== 0 || error !== 1'b0 || min_lat !== 16'd0 || max_lat !== 16'd0) begin
      failures++;
      $display("FAIL count_zero got=ok %0b rises %0d err %b min %0d max %0d exp=ok 1 rises 0 err 0 min 0 max 0",
               ok, rises, error, min_lat, max_lat);
    end
    clear_mon();
    send_cmd(20'hFFFF8, 20'h8, 16'd2, 1'b0, 64'h0, 8'h0);
    wait_done(50, ok);
    checks++;
    if (!ok || addr_q.size() !== 2 || addr_q[0] !== 20'hFFFF8 || addr_q[1] !== 20'h00000) begin
      failures++;
      $display("FAIL addr_wrap got=ok %0b n %0d a0 %h a1 %h exp=ok 1 n 2 a0 ffff8 a1 00000",
               ok, addr_q.size(), addr_q[0], addr_q[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int guard;
    lat_tab = '{3, 3, 3, 3};
    clear_mon();
    send_cmd(20'h0, 20'h8, 16'd8, 1'b0, 64'h0, 8'h0);
    guard = 0;
    while (acc_n < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (acc_n < 2 || mif.start_access !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got=acc %0d sa %b busy %b rdy %b exp=acc>=2 sa 0 busy 0 rdy 1",
               acc_n, mif.start_access, busy, cmd_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lat_tab = '{1, 2, 1, 2};
    clear_mon();
    send_cmd(20'h0, 20'h8, 16'd2, 1'b0, 64'h0, 8'h0);
    wait_done(50, ok);
    checks++;
    if (!ok || rdd_q.size() !== 2 || rdd_q[0] !== 64'hA0 || rdd_q[1] !== 64'hA1 || error !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_burst got=ok %0b n %0d d0 %h d1 %h err %b exp=ok 1 n 2 d0 a0 d1 a1 err 0",
               ok, rdd_q.size(), rdd_q[0], rdd_q[1], error);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    lat_tab = '{TO + 6, TO + 6, TO + 6, TO + 6};
    clear_mon();
    send_cmd(20'h8, 20'h8, 16'd1, 1'b0, 64'h0, 8'h0);
    wait_done(TO + 50, ok);
    checks++;
    if (!ok || error !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flag got=ok %0b err %b exp=ok 1 err 1", ok, error);
    end
    checks++;
    if (rises !== 1 || sa_cycles !== TO + 6 || max_lat !== LW'(TO + 6) || rdd_q.size() !== 1) begin
      failures++;
      $display("FAIL timeout_hold got=rises %0d cycles %0d max %0d reads %0d exp=rises 1 cycles %0d max %0d reads 1",
               rises, sa_cycles, max_lat, rdd_q.size(), TO + 6, TO + 6);
    end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_readback();
    test_misaligned();
    test_count_zero_and_wrap();
    test_reset_mid_burst();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
